// File: rtl/uart_rx_fifo1.sv
// 8N1 UART receiver with a one-byte holding register and valid/ready handoff.
// Samples the synchronized line at mid-bit; a low stop bit flags a framing error and waits out the break.
module uart_rx_fifo1 #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK12M,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_T = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_sync1;
  logic          r_rx_s;
  logic [1:0]    r_arm;
  logic          w_tick_full;
  logic          w_byte_done;

  assign w_tick_full = (r_timer == FULL_T);
  assign w_byte_done = (r_state == S_STOP) && w_tick_full && r_rx_s;
  assign BUSY        = (r_state != S_IDLE);

  always_ff @(posedge CLK12M) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_arm     <= '0;
      DATA      <= 8'h00;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      r_sync1   <= RXD;
      r_rx_s    <= r_sync1;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;

      // After reset the synchronizer still holds its preset ones for two cycles;
      // only accept a start once the real line has been seen idle, so the tail
      // of a frame cut off by reset is never mistaken for a new start bit.
      if (r_arm != 2'd3) begin
        if (r_arm != 2'd2)
          r_arm <= r_arm + 2'd1;
        else if (r_rx_s)
          r_arm <= 2'd3;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s && r_arm == 2'd3) begin
            r_state <= S_START;
            r_timer <= '0;
          end
        end
        S_START: begin
          if (r_timer == HALF_T) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick_full) begin
            r_shift[r_idx] <= r_rx_s;
            r_timer        <= '0;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7)
              r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop-bit leaves half a bit of slack for a back-to-back start.
          if (w_tick_full) begin
            r_timer <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              FRAME_ERR <= 1'b1;
              r_state   <= S_BREAK;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_BREAK: begin
          if (r_rx_s)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_byte_done && (!VALID || READY)) begin
        DATA  <= r_shift;
        VALID <= 1'b1;
      end else if (w_byte_done) begin
        OVERRUN <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo1.sv
// Bench for uart_rx_fifo1: table vectors, hand-built corner sequences and a
// random line checked against a frame-level decoder model.
module tb_uart_rx_fifo1;
  localparam int CPB0 = 8;
  localparam int CPB1 = 104;
  localparam int NR   = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rxd, ready, valid, ferr, ovr, busy;
  logic [7:0] data;
  logic       rst1, rxd1, ready1, valid1, ferr1, ovr1, busy1;
  logic [7:0] data1;

  uart_rx_fifo1 #(.CLKS_PER_BIT(CPB0)) dut (
    .CLK12M(clk), .RESET(rst), .RXD(rxd), .DATA(data), .VALID(valid),
    .READY(ready), .FRAME_ERR(ferr), .OVERRUN(ovr), .BUSY(busy));

  uart_rx_fifo1 #(.CLKS_PER_BIT(CPB1)) dut1 (
    .CLK12M(clk), .RESET(rst1), .RXD(rxd1), .DATA(data1), .VALID(valid1),
    .READY(ready1), .FRAME_ERR(ferr1), .OVERRUN(ovr1), .BUSY(busy1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int n_ferr = 0, n_ovr = 0, n_vrise = 0, n_vcyc = 0, t_vrise = 0, n_vrise1 = 0, got_n = 0;
  logic [7:0] got [0:255];
  logic pv = 1'b0, pf = 1'b0, po = 1'b0, pv1 = 1'b0, pf1 = 1'b0, po1 = 1'b0;
  logic dbl = 1'b0;
  always @(negedge clk) begin
    if (valid && !pv) begin
      n_vrise = n_vrise + 1;
      t_vrise = cyc;
      if (got_n < 256) begin
        got[got_n] = data;
        got_n = got_n + 1;
      end
    end
    if (valid) n_vcyc = n_vcyc + 1;
    if (ferr) n_ferr = n_ferr + 1;
    if (ovr) n_ovr = n_ovr + 1;
    if (valid1 && !pv1) n_vrise1 = n_vrise1 + 1;
    if ((ferr && pf) || (ovr && po) || (ferr1 && pf1) || (ovr1 && po1)) dbl = 1'b1;
    pv = valid; pf = ferr; po = ovr; pv1 = valid1; pf1 = ferr1; po1 = ovr1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int sel, input logic b, input int n);
    if (sel == 0) rxd = b; else rxd1 = b;
    repeat (n) tick();
  endtask

  task automatic pulse_rst(input int sel);
    if (sel == 0) rst = 1'b1; else rst1 = 1'b1;
    tick();
    if (sel == 0) rst = 1'b0; else rst1 = 1'b0;
  endtask

  // One 8N1 frame; rst_pos selects the frame slot (0=start..9=stop) cut by a reset pulse.
  task automatic send(input int sel, input logic [7:0] b, input logic stop, input int rst_pos);
    int n;
    logic [9:0] f;
    n = (sel == 0) ? CPB0 : CPB1;
    f = {stop, b, 1'b0};
    for (int p = 0; p < 10; p++) begin
      if (p == rst_pos) begin
        drive(sel, f[p], n / 2);
        pulse_rst(sel);
        drive(sel, f[p], n - n / 2 - 1);
      end else begin
        drive(sel, f[p], 1);
        if (p == 0 && sel == 0) t_start = cyc;
        repeat (n - 1) tick();
      end
    end
  endtask

  task automatic drain();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // ---------------- random line + frame-level reference ----------------
  bit         line   [NR];
  bit         rdyv   [NR];
  bit         e_done [NR];
  bit         e_ferr [NR];
  bit         e_busy [NR];
  logic [7:0] e_byte [NR];

  function automatic bit rs(input int t);
    return (t >= 2) ? line[t-2] : 1'b1;
  endfunction

  task automatic build_line();
    int t, k, g;
    logic [7:0] b;
    logic s;
    for (int i = 0; i < NR; i++) begin
      line[i] = 1'b1; rdyv[i] = ($urandom_range(0, 2) == 0);
      e_done[i] = 1'b0; e_ferr[i] = 1'b0; e_busy[i] = 1'b0; e_byte[i] = 8'h00;
    end
    t = 12;
    while (t < NR - 300) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        g = $urandom_range(1, 3);
        for (int j = 0; j < g; j++) line[t+j] = 1'b0;
        t += g + $urandom_range(1, 10);
      end else begin
        b = 8'($urandom);
        s = ($urandom_range(0, 5) != 0);
        for (int p = 0; p < 10; p++)
          for (int j = 0; j < CPB0; j++)
            line[t + p*CPB0 + j] = (p == 0) ? 1'b0 : (p == 9) ? s : b[p-1];
        t += 10 * CPB0;
        if (!s) begin
          g = $urandom_range(0, 20);
          for (int j = 0; j < g; j++) line[t+j] = 1'b0;
          t += g;
        end
        t += $urandom_range(0, 12);
      end
    end
  endtask

  // Edge t sees the line value driven two edges earlier; a frame found at edge t
  // is checked mid-start at t+HALF+1, data every bit time after that, stop 9 bits later.
  task automatic decode();
    int cur, t, ts, sp, e;
    logic [7:0] b;
    cur = 0;
    while (cur < NR) begin
      t = cur;
      while (t < NR && rs(t)) t++;
      if (t >= NR) break;
      ts = t + (CPB0 - 1) / 2 + 1;
      if (ts + 9 * CPB0 >= NR) break;
      if (rs(ts)) begin
        for (int i = t; i < ts; i++) e_busy[i] = 1'b1;
        cur = ts + 1;
      end else begin
        for (int i = 0; i < 8; i++) b[i] = rs(ts + CPB0 * (i + 1));
        sp = ts + 9 * CPB0;
        if (rs(sp)) begin
          e_done[sp] = 1'b1; e_byte[sp] = b; e = sp;
        end else begin
          e_ferr[sp] = 1'b1; e = sp + 1;
          while (e < NR && !rs(e)) e++;
        end
        for (int i = t; i < e && i < NR; i++) e_busy[i] = 1'b1;
        cur = e + 1;
      end
    end
  endtask

  task automatic run_random();
    logic mv, eo;
    logic [7:0] md;
    mv = 1'b0; md = 8'h00;
    build_line();
    decode();
    for (int t = 0; t < NR; t++) begin
      rxd = line[t]; ready = rdyv[t];
      tick();
      eo = 1'b0;
      if (e_done[t]) begin
        if (!mv || rdyv[t]) begin mv = 1'b1; md = e_byte[t]; end
        else eo = 1'b1;
      end else if (mv && rdyv[t]) begin
        mv = 1'b0;
      end
      chk("rnd_valid", valid, mv);
      if (mv) chk("rnd_data", data, md);
      chk("rnd_ferr", ferr, e_ferr[t]);
      chk("rnd_ovr", ovr, eo);
      chk("rnd_busy", busy, e_busy[t]);
    end
    ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    int         ef;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [8];
    int bf, bo, bv, bc, bg, b1;
    logic sawb;
    tv[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 0};
    tv[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0};
    tv[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 0};
    tv[3] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 0};
    tv[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 0};
    tv[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tv[6] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 0};
    tv[7] = '{8'hC3, 1'b0, 1'b1, 1'b0, 8'h00, 1};

    rst = 1'b1; rxd = 1'b1; ready = 1'b0;
    rst1 = 1'b1; rxd1 = 1'b1; ready1 = 1'b0;
    tick(); tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid1", valid1, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0; rst1 = 1'b0;
    repeat (6) tick();

    // Latency of one clean frame.
    bf = n_ferr; bo = n_ovr;
    send(0, 8'hA5, 1'b1, -1);
    repeat (2) tick();
    chk("lat_cycles", t_vrise - t_start, 78);
    chk("lat_valid", valid, 1);
    chk("lat_data", data, 8'hA5);
    chk("lat_ferr", n_ferr - bf, 0);
    chk("lat_ovr", n_ovr - bo, 0);

    for (int i = 0; i < 8; i++) begin
      drain();
      ready = tv[i].rdy;
      bf = n_ferr; bo = n_ovr; bv = n_vrise;
      send(0, tv[i].b, tv[i].stop, -1);
      rxd = 1'b1;
      repeat (6) tick();
      chk("vec_valid", valid, tv[i].ev);
      if (tv[i].ev) chk("vec_data", data, tv[i].ed);
      chk("vec_ferr", n_ferr - bf, tv[i].ef);
      chk("vec_ovr", n_ovr - bo, 0);
      chk("vec_busy", busy, 0);
      chk("vec_vrise", n_vrise - bv, tv[i].stop ? 1 : 0);
    end

    // Overrun on back-to-back frames with a stalled consumer.
    drain();
    bo = n_ovr;
    send(0, 8'h3C, 1'b1, -1);
    send(0, 8'hC3, 1'b1, -1);
    repeat (4) tick();
    chk("ovr_valid", valid, 1);
    chk("ovr_data", data, 8'h3C);
    chk("ovr_count", n_ovr - bo, 1);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("ovr_consumed", valid, 0);
    chk("ovr_data_hold", data, 8'h3C);

    // Always-ready consumer, back-to-back frames.
    ready = 1'b1;
    bc = n_vcyc; bg = got_n; bo = n_ovr;
    send(0, 8'h55, 1'b1, -1);
    send(0, 8'h01, 1'b1, -1);
    repeat (4) tick();
    chk("rdy_vcycles", n_vcyc - bc, 2);
    chk("rdy_byte0", got[bg], 8'h55);
    chk("rdy_byte1", got[bg+1], 8'h01);
    chk("rdy_ovr", n_ovr - bo, 0);
    chk("rdy_valid", valid, 0);
    ready = 1'b0;

    // Start-bit glitch.
    bv = n_vrise; sawb = 1'b0;
    rxd = 1'b0; tick(); tick(); rxd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      sawb = sawb | busy;
    end
    chk("glitch_busy_seen", sawb, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_vrise", n_vrise - bv, 0);

    // Framing error followed by a held break.
    bf = n_ferr; bv = n_vrise;
    send(0, 8'hFF, 1'b0, -1);
    repeat (40) tick();
    chk("brk_ferr", n_ferr - bf, 1);
    chk("brk_valid", valid, 0);
    chk("brk_vrise", n_vrise - bv, 0);
    chk("brk_busy", busy, 1);
    rxd = 1'b1;
    tick(); tick();
    chk("brk_busy_hold", busy, 1);
    tick();
    chk("brk_busy_clear", busy, 0);

    // Reset mid-frame, then a clean frame (both bit rates).
    bv = n_vrise; bf = n_ferr; bo = n_ovr;
    send(0, 8'h81, 1'b1, 5);
    repeat (20) tick();
    chk("abort_vrise", n_vrise - bv, 0);
    chk("abort_busy", busy, 0);
    chk("abort_flags", (n_ferr - bf) + (n_ovr - bo), 0);
    send(0, 8'h7E, 1'b1, -1);
    repeat (4) tick();
    chk("abort_next_valid", valid, 1);
    chk("abort_next_data", data, 8'h7E);

    b1 = n_vrise1;
    send(1, 8'h81, 1'b1, 5);
    repeat (20) tick();
    chk("abort104_vrise", n_vrise1 - b1, 0);
    chk("abort104_busy", busy1, 0);
    send(1, 8'h7E, 1'b1, -1);
    repeat (4) tick();
    chk("abort104_valid", valid1, 1);
    chk("abort104_data", data1, 8'h7E);

    rst = 1'b1; tick(); rst = 1'b0;
    repeat (6) tick();
    run_random();

    chk("pulse_width", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
